nes_controller_reader: RTL and testbench

NES_CONTROLLER_READER -- requirements
Module: nes_controller_reader

---
 rtl/nes_controller_reader.sv | 149 ++++++++++++++
 tb/tb_nes_controller_reader.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/nes_controller_reader.sv
// NES pad poller: latch pulse, 7 shift clocks, 8 samples -> button outputs; NES_DEBOUNCE_EN adds 2-poll agreement.
// Latency: DONE/buttons_valid lands 16*HALF_PERIOD+1 clks after the frame_rate strobe.
// Backpressure: none; frame_rate is dropped unless the poller is IDLE (no queuing, no restart).
module nes_controller_reader #(
    parameter int HALF_PERIOD = 150
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_rate,
    input  logic ctrl_data,
    output logic ctrl_latch,
    output logic ctrl_clk,
    output logic button_a,
    output logic button_b,
    output logic button_select,
    output logic button_start,
    output logic button_up,
    output logic button_down,
    output logic button_left,
    output logic button_right,
    output logic buttons_valid
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LATCH    = 3'd1,
        CLK_HIGH = 3'd2,
        CLK_LOW  = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [10:0] LATCH_LAST = 11'(2 * HALF_PERIOD - 1);
    localparam logic [10:0] HALF_LAST  = 11'(HALF_PERIOD - 1);

    state_t      state, state_nxt;
    logic [10:0] cnt, cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic        sample;
    logic [1:0]  data_sync;
    logic [6:0]  shreg;
    logic [7:0]  buttons;
    logic [7:0]  new_sample;

    // Bits arrive A first; after seven shifts shreg holds {Left..A} and bit 7 comes straight from the synchronizer.
    assign new_sample = {~data_sync[1], shreg};

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        sample      = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (frame_rate) begin
                    state_nxt   = LATCH;
                    bit_idx_nxt = 3'd0;
                end
            end
            LATCH: begin
                if (cnt == LATCH_LAST) begin
                    sample      = 1'b1;
                    cnt_nxt     = '0;
                    bit_idx_nxt = 3'd1;
                    state_nxt   = CLK_HIGH;
                end else begin
                    cnt_nxt = cnt + 11'd1;
                end
            end
            CLK_HIGH: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = CLK_LOW;
                end else begin
                    cnt_nxt = cnt + 11'd1;
                end
            end
            CLK_LOW: begin
                if (cnt == HALF_LAST) begin
                    sample  = 1'b1;
                    cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        state_nxt = DONE;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        state_nxt   = CLK_HIGH;
                    end
                end else begin
                    cnt_nxt = cnt + 11'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef NES_DEBOUNCE_EN
    logic [7:0] prev_sample;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            data_sync     <= '0;
            shreg         <= '0;
            buttons       <= '0;
            ctrl_latch    <= 1'b0;
            ctrl_clk      <= 1'b0;
            buttons_valid <= 1'b0;
`ifdef NES_DEBOUNCE_EN
            prev_sample   <= '0;
`endif
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            bit_idx       <= bit_idx_nxt;
            data_sync     <= {data_sync[0], ctrl_data};
            // Pad strobes come from flops fed by next-state so they never glitch or overlap.
            ctrl_latch    <= (state_nxt == LATCH);
            ctrl_clk      <= (state_nxt == CLK_HIGH);
            buttons_valid <= (state_nxt == DONE);
            if (sample && state_nxt != DONE) begin
                shreg <= {~data_sync[1], shreg[6:1]};
            end
            if (sample && state_nxt == DONE) begin
`ifdef NES_DEBOUNCE_EN
                // A bit moves only when two consecutive polls agree on it.
                buttons     <= (new_sample & ~(new_sample ^ prev_sample))
                             | (buttons & (new_sample ^ prev_sample));
                prev_sample <= new_sample;
`else
                buttons     <= new_sample;
`endif
            end
        end
    end

    assign button_a      = buttons[0];
    assign button_b      = buttons[1];
    assign button_select = buttons[2];
    assign button_start  = buttons[3];
    assign button_up     = buttons[4];
    assign button_down   = buttons[5];
    assign button_left   = buttons[6];
    assign button_right  = buttons[7];

endmodule

// File: tb/tb_nes_controller_reader.sv
// Directed bench for nes_controller_reader with a behavioural 4021 pad; HALF_PERIOD=4 so a poll ends at cycle 65.
module tb_nes_controller_reader;

    localparam int HP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic frame_rate = 1'b0;
    logic ctrl_data;
    logic ctrl_latch, ctrl_clk, buttons_valid;
    logic button_a, button_b, button_select, button_start;
    logic button_up, button_down, button_left, button_right;
    logic [7:0] btns;

    nes_controller_reader #(.HALF_PERIOD(HP)) dut (
        .clk(clk), .rst_n(rst_n), .frame_rate(frame_rate), .ctrl_data(ctrl_data),
        .ctrl_latch(ctrl_latch), .ctrl_clk(ctrl_clk),
        .button_a(button_a), .button_b(button_b), .button_select(button_select),
        .button_start(button_start), .button_up(button_up), .button_down(button_down),
        .button_left(button_left), .button_right(button_right), .buttons_valid(buttons_valid)
    );

    always #5 clk = ~clk;

    assign btns = {button_right, button_left, button_down, button_up,
                   button_start, button_select, button_b, button_a};

    // 4021-style pad: parallel load while latched, shift toward Q on ctrl_clk rising, 1s fill in.
    logic [7:0] pad_pressed = 8'h00;
    logic [7:0] pad_sr = 8'hFF;
    logic       pad_clk_d = 1'b0;
    assign ctrl_data = pad_sr[0];
    always @(posedge clk) begin
        if (ctrl_latch) pad_sr <= ~pad_pressed;
        else if (ctrl_clk && !pad_clk_d) pad_sr <= {1'b1, pad_sr[7:1]};
        pad_clk_d <= ctrl_clk;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    int n_valid, valid_cyc, latch_cnt, latch_first, latch_last, clk_rises, clk_hi, overlap;

    // Starts with frame_rate high in cycle 0 (caller is #1 after a posedge) and watches 80 cycles.
    task automatic run_poll(input logic [7:0] pressed, input int fr_again, input int rst_at);
        logic prev_clk;
        pad_pressed = pressed;
        frame_rate  = 1'b1;
        n_valid = 0; valid_cyc = -1; latch_cnt = 0; latch_first = -1; latch_last = -1;
        clk_rises = 0; clk_hi = 0; overlap = 0; prev_clk = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            frame_rate = 1'b0;
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("reset_drops_ctrl_clk", {31'd0, ctrl_clk}, 32'd0);
                check("reset_drops_ctrl_latch", {31'd0, ctrl_latch}, 32'd0);
                check("reset_clears_buttons", {24'd0, btns}, 32'd0);
            end
            if (buttons_valid) begin
                n_valid++;
                valid_cyc = c;
            end
            if (ctrl_latch) begin
                latch_cnt++;
                if (latch_first < 0) latch_first = c;
                latch_last = c;
            end
            if (ctrl_clk) clk_hi++;
            if (ctrl_clk && !prev_clk) clk_rises++;
            prev_clk = ctrl_clk;
            if (ctrl_clk && ctrl_latch) overlap = 1;
            if (c == fr_again) frame_rate = 1'b1;
        end
        if (rst_at > 0) rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] pressed;
        logic [7:0] exp_plain;
        logic [7:0] exp_deb;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [7:0] pick(input vec_t v);
`ifdef NES_DEBOUNCE_EN
        return v.exp_deb;
`else
        return v.exp_plain;
`endif
    endfunction

    initial begin
        vecs[0] = '{8'hFF, 8'hFF, 8'h0A};
        vecs[1] = '{8'hFF, 8'hFF, 8'hFF};
        vecs[2] = '{8'h00, 8'h00, 8'hFF};
        vecs[3] = '{8'h00, 8'h00, 8'h00};
        vecs[4] = '{8'h40, 8'h40, 8'h00};
        vecs[5] = '{8'h00, 8'h00, 8'h00};
        vecs[6] = '{8'h40, 8'h40, 8'h00};
        vecs[7] = '{8'h40, 8'h40, 8'h40};
        vecs[8] = '{8'h81, 8'h81, 8'h40};
        vecs[9] = '{8'h81, 8'h81, 8'h81};

        // Reset with all buttons held: every output forced low immediately and stays low.
        pad_pressed = 8'hFF;
        #2 rst_n = 1'b0;
        #1;
        check("reset_outputs", {21'd0, ctrl_latch, ctrl_clk, buttons_valid, btns}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("idle_outputs", {21'd0, ctrl_latch, ctrl_clk, buttons_valid, btns}, 32'd0);

        // A+Up: waveform timing.
        run_poll(8'h11, -1, -1);
        check("ab_valid_cycle", valid_cyc, 65);
        check("ab_valid_count", n_valid, 1);
        check("ab_latch_first", latch_first, 1);
        check("ab_latch_last", latch_last, 8);
        check("ab_latch_cycles", latch_cnt, 8);
        check("ab_clk_pulses", clk_rises, 7);
        check("ab_clk_high_cycles", clk_hi, 7 * HP);
        check("ab_no_overlap", overlap, 0);
`ifdef NES_DEBOUNCE_EN
        check("ab_buttons", {24'd0, btns}, 32'h00);
`else
        check("ab_buttons", {24'd0, btns}, 32'h11);
`endif

        // Second frame_rate mid-poll must be ignored.
        run_poll(8'h11, 20, -1);
        check("dup_valid_cycle", valid_cyc, 65);
        check("dup_valid_count", n_valid, 1);
        check("dup_latch_cycles", latch_cnt, 8);
        check("dup_latch_last", latch_last, 8);
        check("dup_buttons", {24'd0, btns}, 32'h11);

        // Reset at cycle 30 aborts the poll; a fresh poll then runs normally.
        run_poll(8'h0A, -1, 30);
        check("rst_no_valid", n_valid, 0);
        check("rst_no_clk", clk_rises, 3);
        run_poll(8'h0A, -1, -1);
        check("post_rst_valid_cycle", valid_cyc, 65);
        check("post_rst_latch_cycles", latch_cnt, 8);
`ifdef NES_DEBOUNCE_EN
        check("post_rst_buttons", {24'd0, btns}, 32'h00);
`else
        check("post_rst_buttons", {24'd0, btns}, 32'h0A);
`endif

        // Button sequences: all held, unplugged, single-poll Left, mixed.
        for (int i = 0; i < 10; i++) begin
            run_poll(vecs[i].pressed, -1, -1);
            check($sformatf("vec%0d_valid_cycle", i), valid_cyc, 65);
            check($sformatf("vec%0d_buttons", i), {24'd0, btns}, {24'd0, pick(vecs[i])});
        end

        // Outputs hold between polls.
        pad_pressed = 8'h00;
        repeat (30) @(posedge clk);
        #1;
        check("hold_buttons", {24'd0, btns}, 32'h81);
        check("hold_no_valid", {31'd0, buttons_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
